// File: rtl/mem_arbiter.sv
// Two-port (instruction/data cache) round-robin arbiter in front of a single
// block-wide memory port; one outstanding transaction at a time.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset,

  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,

  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,

  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,

  output logic [15:0]       d_grant_cnt,
  output logic [15:0]       i_grant_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state;
  logic       last_grant;  // 1: port D was granted last, 0: port I
  logic       gnt_d;       // port owning the current transaction

  logic       i_req;
  logic       d_req;
  logic       pick_d;
  logic       pick_write;

  always_comb begin
    i_req      = i_read | i_write;
    d_req      = d_read | d_write;
    // D wins alone, or on a tie when I was served last
    pick_d     = d_req & (~i_req | ~last_grant);
    pick_write = pick_d ? d_write : i_write;
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state       <= IDLE;
      last_grant  <= 1'b0;
      gnt_d       <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      i_ready     <= 1'b0;
      d_ready     <= 1'b0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      i_grant_cnt <= '0;
      d_grant_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req | d_req) begin
            gnt_d     <= pick_d;
            mem_addr  <= pick_d ? d_addr  : i_addr;
            mem_wdata <= pick_d ? d_wdata : i_wdata;
            mem_write <= pick_write;
            mem_read  <= ~pick_write;
            state     <= BUSY;
          end
        end

        BUSY: begin
          if (mem_ready) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (gnt_d) d_ready <= 1'b1;
            else       i_ready <= 1'b1;
            // rdata registers only ever move on a completed read
            if (mem_read) begin
              if (gnt_d) d_rdata <= mem_rdata;
              else       i_rdata <= mem_rdata;
            end
            state <= DONE;
          end
        end

        DONE: begin
          i_ready    <= 1'b0;
          d_ready    <= 1'b0;
          if (gnt_d) d_grant_cnt <= d_grant_cnt + 16'd1;
          else       i_grant_cnt <= i_grant_cnt + 16'd1;
          last_grant <= gnt_d;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; inputs driven and outputs
// sampled on the falling clock edge.
module tb_mem_arbiter;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  logic              clk = 1'b0;
  logic              proc_reset;
  logic              i_read, i_write, d_read, d_write;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [DATA_W-1:0] i_wdata, d_wdata;
  logic [DATA_W-1:0] i_rdata, d_rdata;
  logic              i_ready, d_ready;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_ready;
  logic [15:0]       d_grant_cnt, i_grant_cnt;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .proc_reset(proc_reset),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .d_grant_cnt(d_grant_cnt), .i_grant_cnt(i_grant_cnt)
  );

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    proc_reset = 1'b1;
    i_read = 1'b0; i_write = 1'b0; d_read = 1'b0; d_write = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    proc_reset = 1'b0;
  endtask

  // Waits for a strobe, answers after lat cycles with data; returns in DONE.
  task automatic serve(input int unsigned lat, input logic [DATA_W-1:0] data,
                       output logic saw_write, output logic got_d,
                       output logic got_i);
    logic seen = 1'b0;
    for (int unsigned k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = mem_read | mem_write;
    end
    if (!seen) check("strobe_timeout", '0, 1);
    saw_write = mem_write;
    repeat (lat - 1) @(negedge clk);
    mem_rdata = data;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    got_d = d_ready;
    got_i = i_ready;
  endtask

  logic w, gd, gi;

  initial begin
    proc_reset = 1'b1;
    i_read = 1'b0; i_write = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    proc_reset = 1'b0;

    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_ready", {i_ready, d_ready}, 0);
    check("rst_rdata", i_rdata | d_rdata, 0);
    check("rst_cnts", {i_grant_cnt, d_grant_cnt}, 0);

    // mem_ready while idle must be ignored
    @(negedge clk); mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    check("idle_rdy_ready", {i_ready, d_ready}, 0);
    @(negedge clk);
    check("idle_rdy_cnt", d_grant_cnt, 0);

    // Single D read, mem_ready 3 cycles after the strobe rises
    d_read = 1'b1; d_addr = 28'h0000010;
    @(negedge clk);
    check("rd_strobe", {mem_read, mem_write}, 2'b10);
    check("rd_addr", mem_addr, 28'h0000010);
    repeat (2) @(negedge clk);
    check("rd_strobe_hold", mem_read, 1);
    mem_rdata = {16{8'hA5}}; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; d_read = 1'b0;
    check("rd_d_ready", {d_ready, i_ready}, 2'b10);
    check("rd_d_rdata", d_rdata, {16{8'hA5}});
    check("rd_strobe_drop", mem_read, 0);
    @(negedge clk);
    check("rd_ready_pulse", d_ready, 0);
    check("rd_d_cnt", d_grant_cnt, 1);
    check("rd_rdata_hold", d_rdata, {16{8'hA5}});

    // Tie after reset: D wins, then I
    do_reset();
    i_read = 1'b1; i_addr = 28'h0000020;
    d_write = 1'b1; d_addr = 28'h0000030; d_wdata = 128'hBEEF;
    serve(2, 128'h99, w, gd, gi);
    d_write = 1'b0;
    check("tie1_write", w, 1);
    check("tie1_grant_d", {gd, gi}, 2'b10);
    check("tie1_d_rdata", d_rdata, 0);
    serve(1, 128'h77, w, gd, gi);
    i_read = 1'b0;
    check("tie2_read", w, 0);
    check("tie2_grant_i", {gd, gi}, 2'b01);
    check("tie2_i_rdata", i_rdata, 128'h77);
    @(negedge clk);
    i_read = 1'b1; d_read = 1'b1;
    serve(1, 128'h55, w, gd, gi);
    i_read = 1'b0; d_read = 1'b0;
    check("tie3_grant_d", {gd, gi}, 2'b10);
    check("tie3_i_rdata_hold", i_rdata, 128'h77);

    // Fairness: both request continuously for six transactions
    do_reset();
    i_read = 1'b1; d_read = 1'b1;
    for (int unsigned k = 0; k < 6; k++) begin
      serve(1 + k % 3, 128'(k + 1), w, gd, gi);
      check($sformatf("fair%0d_grant", k), {gd, gi}, (k % 2 == 0) ? 2'b10 : 2'b01);
      check($sformatf("fair%0d_rdata", k), (k % 2 == 0) ? d_rdata : i_rdata, 128'(k + 1));
    end
    i_read = 1'b0; d_read = 1'b0;
    @(negedge clk);
    check("fair_cnts", {i_grant_cnt, d_grant_cnt}, {16'd3, 16'd3});

    // Read+write on I is a write
    do_reset();
    i_read = 1'b1; i_write = 1'b1; i_wdata = 128'h1234; i_addr = 28'h5;
    @(negedge clk);
    check("rw_strobe", {mem_read, mem_write}, 2'b01);
    check("rw_wdata", mem_wdata, 128'h1234);
    mem_rdata = '1; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; i_read = 1'b0; i_write = 1'b0;
    check("rw_ready", i_ready, 1);
    check("rw_i_rdata", i_rdata, 0);

    // Reset while BUSY aborts the transaction
    do_reset();
    d_read = 1'b1; d_addr = 28'h40;
    @(negedge clk);
    check("abort_strobe", mem_read, 1);
    proc_reset = 1'b1;
    @(negedge clk);
    proc_reset = 1'b0; d_read = 1'b0;
    check("abort_strobe_drop", {mem_read, mem_write}, 0);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check("abort_no_ready", {i_ready, d_ready}, 0);
    @(negedge clk);
    check("abort_cnts", {i_grant_cnt, d_grant_cnt}, 0);

    // Counter wrap: preload near the top instead of 65535 real transactions
    do_reset();
    force dut.i_grant_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.i_grant_cnt;
    i_read = 1'b1;
    serve(1, '0, w, gd, gi);
    i_read = 1'b0;
    @(negedge clk);
    check("wrap_ffff", i_grant_cnt, 16'hFFFF);
    i_read = 1'b1;
    serve(1, '0, w, gd, gi);
    i_read = 1'b0;
    @(negedge clk);
    check("wrap_zero", i_grant_cnt, 16'h0000);
    check("wrap_d_cnt", d_grant_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end
endmodule
